// File: rtl/zynq_axil_csr_fifo_bank.sv
//==============================================================================
// Module      : zynq_axil_csr_fifo_bank
// Description : AXI4-Lite slave with NUM_CSR RW control registers and NUM_CH
//               PL->PS FIFOs drained by PS reads. Occupancy registers exist
//               only when ZYNQ_AXIL_BANK_FIFO_STATUS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module zynq_axil_csr_fifo_bank #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_CSR    = 4,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          s00_axi_awaddr,
  input  logic [2:0]                 s00_axi_awprot,
  input  logic                       s00_axi_awvalid,
  output logic                       s00_axi_awready,
  input  logic [DATA_W-1:0]          s00_axi_wdata,
  input  logic [DATA_W/8-1:0]        s00_axi_wstrb,
  input  logic                       s00_axi_wvalid,
  output logic                       s00_axi_wready,
  output logic [1:0]                 s00_axi_bresp,
  output logic                       s00_axi_bvalid,
  input  logic                       s00_axi_bready,
  input  logic [ADDR_W-1:0]          s00_axi_araddr,
  input  logic [2:0]                 s00_axi_arprot,
  input  logic                       s00_axi_arvalid,
  output logic                       s00_axi_arready,
  output logic [DATA_W-1:0]          s00_axi_rdata,
  output logic [1:0]                 s00_axi_rresp,
  output logic                       s00_axi_rvalid,
  input  logic                       s00_axi_rready,
  output logic [NUM_CSR*DATA_W-1:0]  csr_data_o,
  output logic [NUM_CSR-1:0]         csr_wr_o,
  input  logic [NUM_CH-1:0]          ch_v_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]          ch_ready_o
);

  localparam int         PTR_W       = $clog2(FIFO_DEPTH);
  localparam int         STRB_W      = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0]             csr_q [NUM_CSR];
  logic [NUM_CSR-1:0]            csr_wr_q;
  logic                          bvalid_q;
  logic [1:0]                    bresp_q;
  logic                          rvalid_q;
  logic [DATA_W-1:0]             rdata_q;
  logic [1:0]                    rresp_q;

  logic [31:0]                   w_widx;
  logic [31:0]                   w_ridx;
  logic                          w_wr_en;
  logic                          w_rd_en;
  logic                          w_wr_hit;
  logic [DATA_W-1:0]             w_rdata;
  logic [1:0]                    w_rresp;
  logic [NUM_CH-1:0]             w_pop_sel;
  logic [NUM_CH-1:0][DATA_W-1:0] w_head;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_cnt;
  logic                          w_unused;

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign w_widx   = 32'(s00_axi_awaddr[ADDR_W-1:2]);
  assign w_ridx   = 32'(s00_axi_araddr[ADDR_W-1:2]);

  // Ready is combinational so the accept edge is the edge that updates state.
  assign w_wr_en  = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~reset;
  assign w_rd_en  = s00_axi_arvalid & ~rvalid_q & ~reset;
  assign w_wr_hit = (w_widx < 32'(NUM_CSR));

  assign s00_axi_awready = w_wr_en;
  assign s00_axi_wready  = w_wr_en;
  assign s00_axi_arready = w_rd_en;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign csr_wr_o        = csr_wr_q;

  generate
    for (genvar k = 0; k < NUM_CSR; k++) begin : g_csr_out
      assign csr_data_o[k*DATA_W +: DATA_W] = csr_q[k];
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CSR; k++) csr_q[k] <= '0;
      csr_wr_q <= '0;
    end else begin
      csr_wr_q <= '0;
      if (w_wr_en) begin
        for (int k = 0; k < NUM_CSR; k++) begin
          if (w_widx == 32'(k)) begin
            csr_wr_q[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (s00_axi_wstrb[b]) csr_q[k][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (w_wr_en) begin
      bvalid_q <= 1'b1;
      bresp_q  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  always_comb begin
    w_rdata   = '0;
    w_rresp   = RESP_SLVERR;
    w_pop_sel = '0;
    for (int k = 0; k < NUM_CSR; k++) begin
      if (w_ridx == 32'(k)) begin
        w_rdata = csr_q[k];
        w_rresp = RESP_OKAY;
      end
    end
    // An empty FIFO answers SLVERR and is not popped.
    for (int c = 0; c < NUM_CH; c++) begin
      if ((w_ridx == 32'(NUM_CSR + c)) && (w_cnt[c] != '0)) begin
        w_rdata      = w_head[c];
        w_rresp      = RESP_OKAY;
        w_pop_sel[c] = 1'b1;
      end
    end
`ifdef ZYNQ_AXIL_BANK_FIFO_STATUS_EN
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ridx == 32'(NUM_CSR + NUM_CH + c)) begin
        w_rdata = DATA_W'(w_cnt[c]);
        w_rresp = RESP_OKAY;
      end
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (w_rd_en) begin
      rvalid_q <= 1'b1;
      rdata_q  <= w_rdata;
      rresp_q  <= w_rresp;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q;
      logic [PTR_W-1:0]  rd_ptr_q;
      logic [CNT_W-1:0]  cnt_q;
      logic              w_push;
      logic              w_pop;

      // A full FIFO refuses the push even when a pop lands in the same cycle.
      assign ch_ready_o[c] = (cnt_q != CNT_W'(FIFO_DEPTH)) & ~reset;
      assign w_push        = ch_v_i[c] & ch_ready_o[c];
      assign w_pop         = w_rd_en & w_pop_sel[c];
      assign w_head[c]     = mem_q[rd_ptr_q];
      assign w_cnt[c]      = cnt_q;

      always_ff @(posedge aclk) begin
        if (w_push) mem_q[wr_ptr_q] <= ch_data_i[c*DATA_W +: DATA_W];
      end

      always_ff @(posedge aclk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          case ({w_push, w_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
          endcase
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire
